ram_dp_pipe: RTL and testbench

//   Single-clock true dual-port RAM, byte-write, with configurable read latency (1..N registers),
//   per-port read valid strobe, defined cross-port collision handling and a write-write collision flag.

---
 rtl/ram_dp_pipe_if.sv | 23 ++
 rtl/ram_dp_pipe.sv | 129 ++++++++++++
 tb/tb_ram_dp_pipe.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/ram_dp_pipe_if.sv
// One RAM access port: request signals from the user, registered read result back.
interface ram_dp_pipe_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int BYTE_NUM   = 4,
    parameter int MEM_WIDTH  = 32
);
    logic                  en_i;
    logic [BYTE_NUM-1:0]   wr_en_i;
    logic [ADDR_WIDTH-1:0] addr_i;
    logic [MEM_WIDTH-1:0]  data_i;
    logic [MEM_WIDTH-1:0]  data_o;
    logic                  valid_o;

    modport master (
        output en_i, wr_en_i, addr_i, data_i,
        input  data_o, valid_o
    );

    modport slave (
        input  en_i, wr_en_i, addr_i, data_i,
        output data_o, valid_o
    );
endinterface

// File: rtl/ram_dp_pipe.sv
// Single-clock true dual-port byte-write RAM with a pipelined read path of RD_LATENCY stages,
// deterministic cross-port collision results and a write-write collision strobe.
module ram_dp_pipe #(
    parameter int    MEM_DEPTH  = 1024,
    parameter int    BYTE_WIDTH = 8,
    parameter int    BYTE_NUM   = 4,
    parameter int    RD_LATENCY = 2,
    parameter string MEM_MODE   = "no_change",
    parameter string MEM_FILE   = "",
    parameter int    ADDR_WIDTH = $clog2(MEM_DEPTH),
    parameter int    MEM_WIDTH  = BYTE_WIDTH * BYTE_NUM
) (
    input  logic          clk_i,
    input  logic          rst_i,
    ram_dp_pipe_if.slave  a,
    ram_dp_pipe_if.slave  b,
    output logic          coll_o
);

    localparam bit MODE_NC = (MEM_MODE == "no_change");
    localparam bit MODE_WF = (MEM_MODE == "write_first");
    localparam bit MODE_RF = (MEM_MODE == "read_first");
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    if (RD_LATENCY < 1 || RD_LATENCY > 8) begin : g_bad_latency
        $error("ram_dp_pipe: RD_LATENCY must be in 1..8");
    end
    if (!(MODE_NC || MODE_WF || MODE_RF)) begin : g_bad_mode
        $error("ram_dp_pipe: unknown MEM_MODE");
    end

    logic [MEM_WIDTH-1:0] mem [MEM_DEPTH];

    // Index 0 = port A, index 1 = port B
    logic [1:0]                 en_w;
    logic [1:0][BYTE_NUM-1:0]   we_w;
    logic [1:0][ADDR_WIDTH-1:0] addr_w;
    logic [1:0][MEM_WIDTH-1:0]  din_w;

    assign en_w   = {b.en_i,    a.en_i};
    assign we_w   = {b.wr_en_i, a.wr_en_i};
    assign addr_w = {b.addr_i,  a.addr_i};
    assign din_w  = {b.data_i,  a.data_i};

    function automatic logic [MEM_WIDTH-1:0] lane_merge(
        input logic [MEM_WIDTH-1:0] base,
        input logic [MEM_WIDTH-1:0] din,
        input logic [BYTE_NUM-1:0]  we
    );
        logic [MEM_WIDTH-1:0] res;
        res = base;
        for (int l = 0; l < BYTE_NUM; l++) begin
            if (we[l]) res[l*BYTE_WIDTH +: BYTE_WIDTH] = din[l*BYTE_WIDTH +: BYTE_WIDTH];
        end
        return res;
    endfunction

    logic [1:0]                in_rng;
    logic [1:0]                wr_ok;
    logic [1:0]                issue_d;
    logic [1:0][MEM_WIDTH-1:0] old_w;
    logic [1:0][MEM_WIDTH-1:0] own_w;
    logic [1:0][MEM_WIDTH-1:0] rd_d;
    logic [MEM_WIDTH-1:0]      wword_a;
    logic                      same_addr;

    always_comb begin
        in_rng  = '0;
        wr_ok   = '0;
        issue_d = '0;
        old_w   = '0;
        own_w   = '0;
        rd_d    = '0;
        for (int p = 0; p < 2; p++) begin
            in_rng[p] = ({1'b0, addr_w[p]} < DEPTH_L);
            wr_ok[p]  = !rst_i && en_w[p] && in_rng[p] && (we_w[p] != '0);
            if (in_rng[p]) old_w[p] = mem[addr_w[p]];
            own_w[p]  = lane_merge(old_w[p], din_w[p], we_w[p]);
            issue_d[p] = !rst_i && en_w[p] && (!MODE_NC || we_w[p] == '0);
            // Reads always see the pre-write word; only write_first overlays the port's own lanes.
            if (in_rng[p]) rd_d[p] = MODE_WF ? own_w[p] : old_w[p];
        end
        same_addr = (addr_w[0] == addr_w[1]);
        // A is written after B, so A's word carries B's lanes where A does not write them.
        wword_a = lane_merge((same_addr && wr_ok[1]) ? own_w[1] : old_w[0], din_w[0], we_w[0]);
    end

    always_ff @(posedge clk_i) begin
        if (wr_ok[1]) mem[addr_w[1]] <= own_w[1];
        if (wr_ok[0]) mem[addr_w[0]] <= wword_a;
    end

    logic [1:0][RD_LATENCY-1:0][MEM_WIDTH-1:0] pd_q, pd_d;
    logic [1:0][RD_LATENCY-1:0]                pv_q, pv_d;
    logic                                      coll_q, coll_d;

    always_comb begin
        pd_d = pd_q;
        pv_d = pv_q;
        for (int p = 0; p < 2; p++) begin
            pv_d[p][0] = issue_d[p];
            if (issue_d[p]) pd_d[p][0] = rd_d[p];
            for (int s = 1; s < RD_LATENCY; s++) begin
                pv_d[p][s] = pv_q[p][s-1];
                if (pv_q[p][s-1]) pd_d[p][s] = pd_q[p][s-1];
            end
        end
        coll_d = wr_ok[0] && wr_ok[1] && same_addr && ((we_w[0] & we_w[1]) != '0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pd_q   <= '0;
            pv_q   <= '0;
            coll_q <= 1'b0;
        end else begin
            pd_q   <= pd_d;
            pv_q   <= pv_d;
            coll_q <= coll_d;
        end
    end

    assign a.data_o  = pd_q[0][RD_LATENCY-1];
    assign a.valid_o = pv_q[0][RD_LATENCY-1];
    assign b.data_o  = pd_q[1][RD_LATENCY-1];
    assign b.valid_o = pv_q[1][RD_LATENCY-1];
    assign coll_o    = coll_q;

endmodule

// File: tb/tb_ram_dp_pipe.sv
// Directed bench: three RAM instances (no_change/L2, read_first/L1, write_first/L4 depth 1000)
// driven by the same stimulus, each checked at its own latency.
module tb_ram_dp_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        a_en, b_en;
    logic [3:0]  a_we, b_we;
    logic [9:0]  a_addr, b_addr;
    logic [31:0] a_din, b_din;
    logic        coll0, coll1, coll2;

    int n_tests = 0;
    int n_fail  = 0;

    ram_dp_pipe_if #(.ADDR_WIDTH(10), .BYTE_NUM(4), .MEM_WIDTH(32)) a0 ();
    ram_dp_pipe_if #(.ADDR_WIDTH(10), .BYTE_NUM(4), .MEM_WIDTH(32)) b0 ();
    ram_dp_pipe_if #(.ADDR_WIDTH(10), .BYTE_NUM(4), .MEM_WIDTH(32)) a1 ();
    ram_dp_pipe_if #(.ADDR_WIDTH(10), .BYTE_NUM(4), .MEM_WIDTH(32)) b1 ();
    ram_dp_pipe_if #(.ADDR_WIDTH(10), .BYTE_NUM(4), .MEM_WIDTH(32)) a2 ();
    ram_dp_pipe_if #(.ADDR_WIDTH(10), .BYTE_NUM(4), .MEM_WIDTH(32)) b2 ();

    assign a0.en_i = a_en; assign a0.wr_en_i = a_we; assign a0.addr_i = a_addr; assign a0.data_i = a_din;
    assign b0.en_i = b_en; assign b0.wr_en_i = b_we; assign b0.addr_i = b_addr; assign b0.data_i = b_din;
    assign a1.en_i = a_en; assign a1.wr_en_i = a_we; assign a1.addr_i = a_addr; assign a1.data_i = a_din;
    assign b1.en_i = b_en; assign b1.wr_en_i = b_we; assign b1.addr_i = b_addr; assign b1.data_i = b_din;
    assign a2.en_i = a_en; assign a2.wr_en_i = a_we; assign a2.addr_i = a_addr; assign a2.data_i = a_din;
    assign b2.en_i = b_en; assign b2.wr_en_i = b_we; assign b2.addr_i = b_addr; assign b2.data_i = b_din;

    ram_dp_pipe #(.MEM_DEPTH(1024), .RD_LATENCY(2), .MEM_MODE("no_change")) dut0 (
        .clk_i(clk), .rst_i(rst), .a(a0.slave), .b(b0.slave), .coll_o(coll0));
    ram_dp_pipe #(.MEM_DEPTH(1024), .RD_LATENCY(1), .MEM_MODE("read_first")) dut1 (
        .clk_i(clk), .rst_i(rst), .a(a1.slave), .b(b1.slave), .coll_o(coll1));
    ram_dp_pipe #(.MEM_DEPTH(1000), .RD_LATENCY(4), .MEM_MODE("write_first")) dut2 (
        .clk_i(clk), .rst_i(rst), .a(a2.slave), .b(b2.slave), .coll_o(coll2));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        a_en = 1'b0; a_we = 4'h0;
        b_en = 1'b0; b_we = 4'h0;
    endtask

    task automatic a_wr(input logic [9:0] ad, input logic [31:0] d, input logic [3:0] we);
        a_en = 1'b1; a_we = we; a_addr = ad; a_din = d;
    endtask

    task automatic b_wr(input logic [9:0] ad, input logic [31:0] d, input logic [3:0] we);
        b_en = 1'b1; b_we = we; b_addr = ad; b_din = d;
    endtask

    task automatic a_rd(input logic [9:0] ad);
        a_en = 1'b1; a_we = 4'h0; a_addr = ad; a_din = 32'h0;
    endtask

    task automatic b_rd(input logic [9:0] ad);
        b_en = 1'b1; b_we = 4'h0; b_addr = ad; b_din = 32'h0;
    endtask

    initial begin
        rst = 1'b1;
        a_addr = '0; b_addr = '0; a_din = '0; b_din = '0;
        idle();
        tick(); tick();
        chk("rst_a_data_d0",  a0.data_o, 32'h0);
        chk("rst_a_valid_d0", 32'(a0.valid_o), 32'h0);
        chk("rst_b_valid_d1", 32'(b1.valid_o), 32'h0);
        chk("rst_a_data_d2",  a2.data_o, 32'h0);
        chk("rst_coll_d0",    32'(coll0), 32'h0);
        rst = 1'b0;

        // Write then read @5, latency 2 on dut0, 1 on dut1
        a_wr(10'd5, 32'hDEADBEEF, 4'hF); tick();
        a_rd(10'd5); tick(); idle();
        chk("lat2_not_early_d0", 32'(a0.valid_o), 32'h0);
        chk("lat1_valid_d1",     32'(a1.valid_o), 32'h1);
        chk("lat1_data_d1",      a1.data_o, 32'hDEADBEEF);
        tick();
        chk("lat2_valid_d0", 32'(a0.valid_o), 32'h1);
        chk("lat2_data_d0",  a0.data_o, 32'hDEADBEEF);
        tick();
        chk("strobe_1cyc_d0", 32'(a0.valid_o), 32'h0);
        chk("data_hold_d0",   a0.data_o, 32'hDEADBEEF);

        // Back-to-back reads on B
        for (int i = 0; i < 8; i++) begin
            a_wr(10'(i), 32'h100 + 32'(i), 4'hF); tick();
        end
        idle();
        for (int i = 0; i < 10; i++) begin
            if (i < 8) b_rd(10'(i));
            else begin b_en = 1'b0; b_we = 4'h0; end
            tick();
            if (i >= 1 && i <= 8) begin
                chk("b2b_valid_d0", 32'(b0.valid_o), 32'h1);
                chk("b2b_data_d0",  b0.data_o, 32'h100 + 32'(i - 1));
            end
            if (i == 9) chk("b2b_end_d0", 32'(b0.valid_o), 32'h0);
        end
        idle();

        // Write-write collision, overlapping lanes
        a_wr(10'd9, 32'h99999999, 4'hF); tick();
        a_wr(10'd9, 32'h11111111, 4'b0011);
        b_wr(10'd9, 32'h22222222, 4'b0110); tick(); idle();
        chk("coll_overlap_d0", 32'(coll0), 32'h1);
        tick();
        chk("coll_strobe_d0", 32'(coll0), 32'h0);

        // Disjoint lanes merge without a flag
        a_wr(10'd10, 32'h0, 4'hF); tick();
        a_wr(10'd10, 32'h000000AA, 4'b0001);
        b_wr(10'd10, 32'h0000BB00, 4'b0010); tick(); idle();
        chk("coll_disjoint_d0", 32'(coll0), 32'h0);
        a_rd(10'd9); tick();
        a_rd(10'd10); tick(); idle();
        chk("coll_word9_valid_d0", 32'(a0.valid_o), 32'h1);
        chk("coll_word9_d0",       a0.data_o, 32'h99221111);
        tick();
        chk("merge_word10_d0", a0.data_o, 32'h0000BBAA);

        // Write on A while B reads the same address
        a_wr(10'd3, 32'hAAAAAAAA, 4'hF); tick();
        a_wr(10'd3, 32'h55555555, 4'hF);
        b_rd(10'd3); tick(); idle();
        chk("xport_b_d1",       b1.data_o, 32'hAAAAAAAA);
        chk("rf_a_valid_d1",    32'(a1.valid_o), 32'h1);
        chk("rf_a_data_d1",     a1.data_o, 32'hAAAAAAAA);
        tick();
        chk("xport_b_valid_d0", 32'(b0.valid_o), 32'h1);
        chk("xport_b_d0",       b0.data_o, 32'hAAAAAAAA);
        chk("nc_a_novalid_d0",  32'(a0.valid_o), 32'h0);
        chk("nc_a_hold_d0",     a0.data_o, 32'h0000BBAA);
        tick(); tick();
        chk("xport_b_d2",    b2.data_o, 32'hAAAAAAAA);
        chk("wf_a_valid_d2", 32'(a2.valid_o), 32'h1);
        chk("wf_a_data_d2",  a2.data_o, 32'h55555555);

        // write_first partial-lane overlay
        a_wr(10'd20, 32'h12345678, 4'hF); tick();
        a_wr(10'd20, 32'hCC000000, 4'b1000); tick(); idle();
        chk("rf_partial_d1", a1.data_o, 32'h12345678);
        tick();
        chk("nc_wr_novalid_d0", 32'(a0.valid_o), 32'h0);
        tick(); tick();
        chk("wf_partial_d2", a2.data_o, 32'hCC345678);

        // Address beyond depth 1000 on dut2
        a_wr(10'd1000, 32'hFFFFFFFF, 4'hF); tick();
        a_rd(10'd1000); tick(); idle();
        tick();
        chk("inrange_1000_d0", a0.data_o, 32'hFFFFFFFF);
        tick(); tick();
        chk("oor_valid_d2", 32'(a2.valid_o), 32'h1);
        chk("oor_data_d2",  a2.data_o, 32'h0);

        // Reset flushes in-flight reads and blocks writes
        a_wr(10'd6, 32'h66666666, 4'hF); tick(); idle();
        tick(); tick(); tick(); tick();
        chk("pre_rst_data_d2", a2.data_o, 32'h66666666);
        a_rd(10'd5); tick();
        a_rd(10'd5); tick();
        rst = 1'b1;
        a_wr(10'd6, 32'h77777777, 4'hF); tick();
        rst = 1'b0; idle();
        chk("flush_valid_d0", 32'(a0.valid_o), 32'h0);
        chk("flush_data_d0",  a0.data_o, 32'h0);
        for (int j = 0; j < 6; j++) begin
            chk("flush_valid_d2", 32'(a2.valid_o), 32'h0);
            chk("flush_data_d2",  a2.data_o, 32'h0);
            tick();
        end
        a_rd(10'd6); tick(); idle();
        tick();
        chk("rst_wr_blocked_valid_d0", 32'(a0.valid_o), 32'h1);
        chk("rst_wr_blocked_d0",       a0.data_o, 32'h66666666);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
